line_frame_counter: RTL and testbench
=====================================

LINE_FRAME_COUNTER -- requirements
Module: line_frame_counter

Interface
REQ-001 The block SHALL have parameter LINE_W, default 10, setting the width of the line counter and of lines_per_frame.
REQ-002 The block SHALL have parameter FRAME_W, default 8, setting the width of the frame counter.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock.
REQ-004 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-005 The block SHALL have port enb, input, 1 bit: active-high enable; low means clear and idle.
REQ-006 The block SHALL have port mode, input, 1 bit: 0 = continuous frames, 1 = single-shot frame.
REQ-007 The block SHALL have port newLine, input, 1 bit: line strobe; only its rising edge counts.
REQ-008 The block SHALL have port lines_per_frame, input, LINE_W bits: lines per frame N; 0 means 2^LINE_W.
REQ-009 The block SHALL have port line_idx, output, LINE_W bits: current line index, 0..N-1.
REQ-010 The block SHALL have port frame_cnt, output, FRAME_W bits: completed frames, modulo 2^FRAME_W.
REQ-011 The block SHALL have port endFrame, output, 1 bit: registered one-cycle pulse on frame completion.
REQ-012 The block SHALL have port lastLine, output, 1 bit: high while line_idx == N-1 in RUN.
REQ-013 The block SHALL have port busy, output, 1 bit: high in RUN.
REQ-014 The block SHALL have port overrun, output, 1 bit: sticky flag for a line edge arriving in DONE.

Function
REQ-015 Edge detection SHALL register newLine into newLine_d every cycle in all states, with edge = newLine & ~newLine_d; a level held high SHALL count once.
REQ-016 The FSM SHALL have three states, IDLE, RUN and DONE, with the transitions below.
- IDLE: enb=1 moves to RUN next cycle, latches N, sets line_idx=0; any edge in this cycle is ignored.
- RUN: on an edge with line_idx != N-1, line_idx increments.
- RUN: on an edge with line_idx == N-1, line_idx becomes 0, frame_cnt increments, and endFrame is high for exactly the next cycle.
- RUN, after a completed frame: mode=0 stays in RUN and relatches N; mode=1 goes to DONE.
- DONE: counters hold; any edge sets overrun.
REQ-017 N SHALL be latched only at frame start, so a change to lines_per_frame mid-frame SHALL take effect on the next frame.
REQ-018 mode SHALL be sampled at frame completion only.
REQ-019 enb=0 in any state SHALL, at the next clock edge, force IDLE and clear line_idx, frame_cnt, endFrame and overrun; enb=0 SHALL take priority over a simultaneous edge.
REQ-020 frame_cnt SHALL wrap from 2^FRAME_W-1 to 0 without any flag; line_idx SHALL never exceed N-1.
REQ-021 With N=1, every edge in RUN SHALL produce endFrame, and lastLine SHALL be constantly high in RUN.
REQ-022 All outputs SHALL be registered, except lastLine and busy, which SHALL be decoded from registered state only.

Reset
REQ-023 rst_n low SHALL immediately force IDLE, line_idx=0, frame_cnt=0, endFrame=0, overrun=0, newLine_d=0, latched N=0 and busy=0.
REQ-024 Reset assertion mid-frame SHALL discard the frame in progress without an endFrame pulse.
REQ-025 After rst_n deasserts, the first newLine rising edge SHALL be detected normally, including when newLine is already high, because newLine_d=0.

Structure
REQ-026 A shared package frame_cnt_pkg SHALL hold the state encoding (IDLE=2'b00, RUN=2'b01, DONE=2'b10) and the mode constants MODE_CONT=0 and MODE_SINGLE=1.
REQ-027 Rising-edge detection SHALL be a separate sub-module, edge_detect, with ports clk, rst_n, in and rise.

Verification
REQ-028 LINE_W=10, N=24, mode=0, 48 strobes -> endFrame pulses after strobes 24 and 48 only, frame_cnt=2, line_idx=0.
REQ-029 newLine held high for 5 cycles, then low -> line_idx advances by exactly 1.
REQ-030 N=3, mode=1, 5 strobes -> endFrame once, state DONE, busy=0, overrun=1, line_idx=0, frame_cnt=1.
REQ-031 enb dropped at line_idx=10 together with a strobe -> next cycle line_idx=0, frame_cnt=0, no endFrame.
REQ-032 lines_per_frame changed from 24 to 8 at line 5 -> the current frame ends after 24 lines and the next after 8.
REQ-033 FRAME_W=8, N=1, 257 strobes -> frame_cnt=1 after wrap; rst_n pulsed mid-run -> all outputs 0 immediately.

Source files
------------

// File: rtl/frame_cnt_pkg.sv
// Shared definitions for the line/frame counter: FSM encoding and mode values.
package frame_cnt_pkg;

  // Counter FSM states.
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

  // Values of the mode input.
  localparam logic MODE_CONT   = 1'b0;
  localparam logic MODE_SINGLE = 1'b1;

endpackage

// File: rtl/line_frame_counter_edge_detect.sv
// Rising-edge detector: a level held high produces a single one-cycle rise.
module edge_detect (
  input  logic clk,
  input  logic rst_n,
  input  logic in,
  output logic rise
);

  logic in_d;

  // Delayed copy of the input. It clears on reset so that an input which is
  // already high when reset releases is still seen as a rising edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_d <= 1'b0;
    end else begin
      in_d <= in;
    end
  end

  assign rise = in & ~in_d;

endmodule

// File: rtl/line_frame_counter.sv
// Line / frame counter driven by a line strobe.
// Counts strobe rising edges into line_idx (0..N-1). Each time a frame
// completes, frame_cnt advances and endFrame pulses for one cycle. In
// continuous mode the next frame starts at once with a freshly latched N; in
// single-shot mode the block parks in DONE and flags further strobes as
// overrun. Dropping enb clears everything and returns the block to IDLE.
// The state output reflects the FSM state register for observation only.
//
// lines_per_frame is sampled at frame start only, so it may change at any
// time without disturbing the frame in progress. The value 0 encodes
// 2^LINE_W lines, which falls out naturally because N-1 wraps to all ones.
module line_frame_counter
  import frame_cnt_pkg::*;
#(
  parameter int LINE_W  = 10,
  parameter int FRAME_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               enb,
  input  logic               mode,
  input  logic               newLine,
  input  logic [LINE_W-1:0]  lines_per_frame,
  output logic [LINE_W-1:0]  line_idx,
  output logic [FRAME_W-1:0] frame_cnt,
  output logic               endFrame,
  output logic               lastLine,
  output logic               busy,
  output logic               overrun,
  output state_t             state
);

  localparam logic [LINE_W-1:0]  LINE_ONE  = LINE_W'(1);
  localparam logic [FRAME_W-1:0] FRAME_ONE = FRAME_W'(1);

  state_t             state_q;
  state_t             state_d;
  logic [LINE_W-1:0]  n_q;
  logic [LINE_W-1:0]  n_d;
  logic [LINE_W-1:0]  line_idx_d;
  logic [FRAME_W-1:0] frame_cnt_d;
  logic               end_frame_d;
  logic               overrun_d;
  logic [LINE_W-1:0]  last_idx;
  logic               at_last;
  logic               line_rise;

  edge_detect u_edge (
    .clk   (clk),
    .rst_n (rst_n),
    .in    (newLine),
    .rise  (line_rise)
  );

  // Index of the final line of the current frame (all ones when N is 0).
  assign last_idx = n_q - LINE_ONE;
  assign at_last  = (line_idx == last_idx);

  // State register and all registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      n_q       <= '0;
      line_idx  <= '0;
      frame_cnt <= '0;
      endFrame  <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      state_q   <= state_d;
      n_q       <= n_d;
      line_idx  <= line_idx_d;
      frame_cnt <= frame_cnt_d;
      endFrame  <= end_frame_d;
      overrun   <= overrun_d;
    end
  end

  // Next-state and next-counter logic; enb low overrides everything.
  always_comb begin
    state_d     = state_q;
    n_d         = n_q;
    line_idx_d  = line_idx;
    frame_cnt_d = frame_cnt;
    end_frame_d = 1'b0;
    overrun_d   = overrun;
    if (!enb) begin
      state_d     = IDLE;
      line_idx_d  = '0;
      frame_cnt_d = '0;
      overrun_d   = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          // Start a frame; a strobe edge in this cycle is not counted.
          state_d    = RUN;
          n_d        = lines_per_frame;
          line_idx_d = '0;
        end
        RUN: begin
          if (line_rise) begin
            if (at_last) begin
              line_idx_d  = '0;
              frame_cnt_d = frame_cnt + FRAME_ONE;
              end_frame_d = 1'b1;
              if (mode == MODE_SINGLE) begin
                state_d = DONE;
              end else begin
                n_d = lines_per_frame;
              end
            end else begin
              line_idx_d = line_idx + LINE_ONE;
            end
          end
        end
        DONE: begin
          if (line_rise) begin
            overrun_d = 1'b1;
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  assign busy     = (state_q == RUN);
  assign lastLine = (state_q == RUN) && at_last;
  assign state    = state_q;

endmodule

// File: tb/tb_line_frame_counter.sv
// Testbench for line_frame_counter: directed scenarios plus a random run,
// checked against a strobe-counting reference model. Each completed frame
// pushes its expected frame count into a queue; a monitor pops it whenever
// the DUT pulses endFrame.
module tb_line_frame_counter;

  localparam int LINE_W  = 10;
  localparam int FRAME_W = 8;

  // Clock and reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic               enb = 1'b0;
  logic               mode = 1'b0;
  logic               newLine = 1'b0;
  logic [LINE_W-1:0]  lines_per_frame = '0;
  logic [LINE_W-1:0]  line_idx;
  logic [FRAME_W-1:0] frame_cnt;
  logic               endFrame;
  logic               lastLine;
  logic               busy;
  logic               overrun;
  logic [1:0]         state;

  line_frame_counter #(.LINE_W(LINE_W), .FRAME_W(FRAME_W)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .enb             (enb),
    .mode            (mode),
    .newLine         (newLine),
    .lines_per_frame (lines_per_frame),
    .line_idx        (line_idx),
    .frame_cnt       (frame_cnt),
    .endFrame        (endFrame),
    .lastLine        (lastLine),
    .busy            (busy),
    .overrun         (overrun),
    .state           (state)
  );

  int compared   = 0;
  int mismatched = 0;

  logic [FRAME_W-1:0] exp_q[$];

  // Reference model: phase 0 idle, 1 counting, 2 finished single shot.
  int m_phase = 0;
  int m_lines = 0;
  int m_idx   = 0;
  int m_frames = 0;
  bit m_ov    = 1'b0;
  bit m_pulse = 1'b0;
  bit m_prev  = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    compared++;
    if (act != exp) begin
      mismatched++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int frame_len();
    return (lines_per_frame == 0) ? (1 << LINE_W) : int'(lines_per_frame);
  endfunction

  // Advance the model by one clock using the inputs currently applied.
  task automatic model_step();
    bit strobe_edge;
    strobe_edge = newLine && !m_prev;
    m_prev  = newLine;
    m_pulse = 1'b0;
    if (!enb) begin
      m_phase = 0; m_idx = 0; m_frames = 0; m_ov = 1'b0;
    end else if (m_phase == 0) begin
      m_phase = 1; m_lines = frame_len(); m_idx = 0;
    end else if (m_phase == 1) begin
      if (strobe_edge) begin
        if (m_idx + 1 == m_lines) begin
          m_idx    = 0;
          m_frames = (m_frames + 1) % (1 << FRAME_W);
          m_pulse  = 1'b1;
          exp_q.push_back(FRAME_W'(m_frames));
          if (mode) m_phase = 2;
          else m_lines = frame_len();
        end else begin
          m_idx = m_idx + 1;
        end
      end
    end else if (strobe_edge) begin
      m_ov = 1'b1;
    end
  endtask

  task automatic model_reset();
    m_phase = 0; m_lines = 0; m_idx = 0; m_frames = 0;
    m_ov = 1'b0; m_pulse = 1'b0; m_prev = 1'b0;
  endtask

  task automatic check_outputs();
    check("line_idx", int'(line_idx), m_idx);
    check("frame_cnt", int'(frame_cnt), m_frames);
    check("endFrame", int'(endFrame), int'(m_pulse));
    check("busy", int'(busy), (m_phase == 1) ? 1 : 0);
    check("lastLine", int'(lastLine), (m_phase == 1 && m_idx + 1 == m_lines) ? 1 : 0);
    check("overrun", int'(overrun), int'(m_ov));
    check("state", int'(state), m_phase);
  endtask

  // Driver tasks
  task automatic cycle();
    model_step();
    @(posedge clk);
    #1;
    check_outputs();
  endtask

  task automatic strobe(input int hi, input int lo);
    newLine = 1'b1;
    repeat (hi) cycle();
    newLine = 1'b0;
    repeat (lo) cycle();
  endtask

  task automatic strobes(input int count);
    for (int i = 0; i < count; i++) strobe(1, $urandom_range(1, 2));
  endtask

  task automatic start(input int n, input bit m);
    enb = 1'b0;
    newLine = 1'b0;
    cycle();
    lines_per_frame = LINE_W'(n);
    mode = m;
    enb = 1'b1;
    cycle();
  endtask

  // Asynchronous reset applied between clock edges, after any pending
  // endFrame pulse has been seen by the monitor.
  task automatic async_reset();
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    model_reset();
    check("rst_line_idx", int'(line_idx), 0);
    check("rst_frame_cnt", int'(frame_cnt), 0);
    check("rst_endFrame", int'(endFrame), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_lastLine", int'(lastLine), 0);
    check("rst_overrun", int'(overrun), 0);
    check("rst_state", int'(state), 0);
    check("rst_pending", exp_q.size(), 0);
    @(negedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // Scoreboard monitor: every endFrame pulse must match a queued frame.
  always @(negedge clk) begin
    if (rst_n && endFrame) begin
      if (exp_q.size() == 0) begin
        check("endFrame_unexpected", 1, 0);
      end else begin
        check("endFrame_frame_cnt", int'(frame_cnt), int'(exp_q.pop_front()));
      end
    end
  end

  initial begin
    // Power-on reset with the strobe already high.
    newLine = 1'b1;
    enb = 1'b1;
    lines_per_frame = 10'd4;
    #2;
    model_reset();
    check("por_line_idx", int'(line_idx), 0);
    check("por_busy", int'(busy), 0);
    check("por_state", int'(state), 0);
    @(negedge clk);
    #1;
    rst_n = 1'b1;
    repeat (3) cycle();
    newLine = 1'b0;
    strobes(6);

    // 24-line continuous frames, 48 strobes.
    start(24, 1'b0);
    strobes(48);
    check("cont_frame_cnt", int'(frame_cnt), 2);
    check("cont_line_idx", int'(line_idx), 0);

    // A held strobe counts once.
    start(24, 1'b0);
    strobe(5, 2);
    check("held_line_idx", int'(line_idx), 1);

    // Single shot with N=3 and two extra strobes.
    start(3, 1'b1);
    strobes(5);
    check("single_state", int'(state), 2);
    check("single_busy", int'(busy), 0);
    check("single_overrun", int'(overrun), 1);
    check("single_frame_cnt", int'(frame_cnt), 1);
    check("single_line_idx", int'(line_idx), 0);

    // enb dropped together with a strobe at line 10.
    start(24, 1'b0);
    strobes(10);
    check("pre_drop_line_idx", int'(line_idx), 10);
    newLine = 1'b1;
    enb = 1'b0;
    cycle();
    check("drop_line_idx", int'(line_idx), 0);
    check("drop_endFrame", int'(endFrame), 0);
    newLine = 1'b0;
    cycle();

    // Frame length changed mid-frame.
    start(24, 1'b0);
    strobes(5);
    lines_per_frame = 10'd8;
    strobes(18);
    check("relatch_not_yet", int'(frame_cnt), 0);
    strobes(1);
    check("relatch_first", int'(frame_cnt), 1);
    strobes(8);
    check("relatch_second", int'(frame_cnt), 2);

    // N=1 wrap of the frame counter, then reset mid-run.
    start(1, 1'b0);
    strobes(257);
    check("wrap_frame_cnt", int'(frame_cnt), 1);
    async_reset();
    repeat (2) cycle();

    // N=0 means 2^LINE_W lines.
    start(0, 1'b0);
    strobes(1023);
    check("full_not_yet", int'(frame_cnt), 0);
    strobes(1);
    check("full_frame", int'(frame_cnt), 1);

    // Random run over small frame lengths.
    start(3, 1'b0);
    for (int i = 0; i < 2500; i++) begin
      enb = ($urandom_range(0, 59) != 0);
      newLine = $urandom_range(0, 1);
      if ($urandom_range(0, 9) == 0) mode = $urandom_range(0, 1);
      if ($urandom_range(0, 19) == 0) lines_per_frame = LINE_W'($urandom_range(0, 5));
      if (lines_per_frame == 0 && $urandom_range(0, 1) == 0) lines_per_frame = 10'd2;
      cycle();
    end

    newLine = 1'b0;
    repeat (3) cycle();
    @(negedge clk);
    #1;
    check("pending_frames", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
